// File: rtl/stb_seq.sv
// Measurement sequencer for the strobe generator: frequency-detect phase, strobe
// collection with period measurement and inter-strobe timeout supervision.
module stb_seq #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned TMR_W = 24
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] n_stb_i,
    input  logic [TMR_W-1:0] det_cycles_i,
    input  logic [TMR_W-1:0] timeout_i,
    input  logic             stb_i,
    input  logic             gen_err_i,
    output logic             freq_det_o,
    output logic             oe_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [1:0]       err_code_o,
    output logic [CNT_W-1:0] stb_cnt_o,
    output logic [TMR_W-1:0] period_o
);

    typedef enum logic [1:0] {StIdle, StDet, StRun, StDone} state_e;

    localparam logic [1:0] ErrOk      = 2'd0;
    localparam logic [1:0] ErrTimeout = 2'd1;
    localparam logic [1:0] ErrGen     = 2'd2;
    localparam logic [1:0] ErrBadCfg  = 2'd3;

    state_e           state_q;
    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timeout_q;
    logic [CNT_W-1:0] n_stb_q;
    logic             stb_q;

    logic             stb_evt;
    logic [CNT_W-1:0] cnt_inc;
    logic             last_stb;
    logic             timeout_hit;
    logic             fin;
    logic [1:0]       fin_code;

    assign stb_evt     = stb_i & ~stb_q;
    assign cnt_inc     = stb_cnt_o + CNT_W'(1);
    assign last_stb    = stb_evt && (cnt_inc == n_stb_q);
    assign timeout_hit = (timeout_q != '0) && (timer_q == timeout_q) && !stb_evt;

    // Sequence termination decode; abort suppresses any completion in the same cycle.
    always_comb begin
        fin      = 1'b0;
        fin_code = ErrOk;
        if ((state_q == StDet || state_q == StRun) && !abort_i) begin
            if (gen_err_i) begin
                fin      = 1'b1;
                fin_code = ErrGen;
            end else if (state_q == StRun) begin
                if (last_stb) begin
                    fin      = 1'b1;
                    fin_code = ErrOk;
                end else if (timeout_hit) begin
                    fin      = 1'b1;
                    fin_code = ErrTimeout;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            timeout_q  <= '0;
            n_stb_q    <= '0;
            stb_q      <= 1'b0;
            freq_det_o <= 1'b0;
            oe_o       <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            err_code_o <= ErrOk;
            stb_cnt_o  <= '0;
            period_o   <= '0;
        end else begin
            stb_q  <= stb_i;
            done_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    freq_det_o <= 1'b0;
                    oe_o       <= 1'b0;
                    busy_o     <= 1'b0;
                    if (start_i) begin
                        n_stb_q    <= n_stb_i;
                        timeout_q  <= timeout_i;
                        stb_cnt_o  <= '0;
                        period_o   <= '0;
                        err_o      <= 1'b0;
                        err_code_o <= ErrOk;
                        busy_o     <= 1'b1;
                        if (n_stb_i == '0) begin
                            state_q    <= StDone;
                            done_o     <= 1'b1;
                            err_o      <= 1'b1;
                            err_code_o <= ErrBadCfg;
                        end else begin
                            state_q    <= StDet;
                            freq_det_o <= 1'b1;
                            timer_q    <= (det_cycles_i == '0) ? TMR_W'(1) : det_cycles_i;
                        end
                    end
                end
                StDet, StRun: begin
                    if (abort_i) begin
                        state_q    <= StIdle;
                        freq_det_o <= 1'b0;
                        oe_o       <= 1'b0;
                        busy_o     <= 1'b0;
                    end else begin
                        if (state_q == StDet) begin
                            if (timer_q == TMR_W'(1)) begin
                                state_q    <= StRun;
                                freq_det_o <= 1'b0;
                                oe_o       <= 1'b1;
                                timer_q    <= TMR_W'(1);
                            end else begin
                                timer_q <= timer_q - TMR_W'(1);
                            end
                        end else if (!gen_err_i) begin
                            if (stb_evt) begin
                                stb_cnt_o <= cnt_inc;
                                if (stb_cnt_o != '0) period_o <= timer_q;
                                timer_q <= TMR_W'(1);
                            end else if (timer_q != '1) begin
                                timer_q <= timer_q + TMR_W'(1);
                            end
                        end
                        if (fin) begin
                            state_q    <= StDone;
                            done_o     <= 1'b1;
                            freq_det_o <= 1'b0;
                            oe_o       <= 1'b0;
                            err_o      <= (fin_code != ErrOk);
                            err_code_o <= fin_code;
                        end
                    end
                end
                StDone: begin
                    state_q    <= StIdle;
                    busy_o     <= 1'b0;
                    freq_det_o <= 1'b0;
                    oe_o       <= 1'b0;
                end
            endcase
        end
    end

endmodule
